// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring
// divide on operand magnitudes, followed by a single sign-fix cycle.
module muldiv_unit #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int unsigned CNT_W = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        f3_q, f3_d;
   logic              neg_a_q, neg_a_d;
   logic              neg_b_q, neg_b_d;
   logic              div0_q, div0_d;
   logic              ovf_q, ovf_d;
   logic [XLEN-1:0]   a_q, a_d;
   logic [XLEN-1:0]   opnd_q, opnd_d;
   logic [XLEN-1:0]   hi_q, hi_d;
   logic [XLEN-1:0]   lo_q, lo_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [XLEN-1:0]   result_q, result_d;

   logic              accept_c, special_c, sgn_a_c, sgn_b_c, div0_c, ovf_c;
   logic [XLEN-1:0]   mag_a_c, mag_b_c;
   logic [XLEN:0]     sum_c, shifted_c, diff_c;
   logic [2*XLEN-1:0] prod_c;
   logic [XLEN-1:0]   quot_c, rem_c, fix_res_c;

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

   // Acceptance decode: operand signedness, magnitudes and divide special cases
   always_comb begin
      accept_c  = start & ((state_q == S_IDLE) | (state_q == S_DONE));
      sgn_a_c   = op_a[XLEN-1] & (funct3 != 3'b011) & (funct3 != 3'b101) & (funct3 != 3'b111);
      sgn_b_c   = op_b[XLEN-1] & (funct3 != 3'b010) & (funct3 != 3'b011) &
                  (funct3 != 3'b101) & (funct3 != 3'b111);
      mag_a_c   = sgn_a_c ? -op_a : op_a;
      mag_b_c   = sgn_b_c ? -op_b : op_b;
      div0_c    = funct3[2] & (op_b == '0);
      ovf_c     = funct3[2] & ~funct3[0] & (op_a == MIN_NEG) & (&op_b);
      special_c = div0_c | ovf_c;
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         f3_q     <= '0;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
         div0_q   <= 1'b0;
         ovf_q    <= 1'b0;
         a_q      <= '0;
         opnd_q   <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         f3_q     <= f3_d;
         neg_a_q  <= neg_a_d;
         neg_b_q  <= neg_b_d;
         div0_q   <= div0_d;
         ovf_q    <= ovf_d;
         a_q      <= a_d;
         opnd_q   <= opnd_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

   // Next-state: DONE accepts like IDLE; special divides skip the iterations
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (accept_c) state_d = special_c ? S_FIX : S_ITER;
            else          state_d = S_IDLE;
         end
         S_ITER:  if (cnt_q == CNT_W'(XLEN-1)) state_d = S_FIX;
         S_FIX:   state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   // Iteration step (hi:lo is product or remainder:quotient) and FIX result
   always_comb begin
      cnt_d    = cnt_q;
      f3_d     = f3_q;
      neg_a_d  = neg_a_q;
      neg_b_d  = neg_b_q;
      div0_d   = div0_q;
      ovf_d    = ovf_q;
      a_d      = a_q;
      opnd_d   = opnd_q;
      hi_d     = hi_q;
      lo_d     = lo_q;

      sum_c     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
      shifted_c = {hi_q, lo_q[XLEN-1]};
      diff_c    = shifted_c - {1'b0, opnd_q};

      prod_c = {hi_q, lo_q};
      if (neg_a_q ^ neg_b_q) prod_c = -prod_c;
      quot_c = (neg_a_q ^ neg_b_q) ? -lo_q : lo_q;
      rem_c  = neg_a_q ? -hi_q : hi_q;

      if (!f3_q[2])       fix_res_c = (f3_q[1:0] == 2'b00) ? prod_c[XLEN-1:0] : prod_c[2*XLEN-1:XLEN];
      else if (div0_q)    fix_res_c = f3_q[1] ? a_q : '1;
      else if (ovf_q)     fix_res_c = f3_q[1] ? '0 : MIN_NEG;
      else                fix_res_c = f3_q[1] ? rem_c : quot_c;

      if (accept_c) begin
         cnt_d   = '0;
         f3_d    = funct3;
         neg_a_d = sgn_a_c;
         neg_b_d = sgn_b_c;
         div0_d  = div0_c;
         ovf_d   = ovf_c;
         a_d     = op_a;
         opnd_d  = funct3[2] ? mag_b_c : mag_a_c;
         lo_d    = funct3[2] ? mag_a_c : mag_b_c;
         hi_d    = '0;
      end else if (state_q == S_ITER) begin
         cnt_d = cnt_q + CNT_W'(1);
         if (!f3_q[2]) begin
            hi_d = sum_c[XLEN:1];
            lo_d = {sum_c[0], lo_q[XLEN-1:1]};
         end else if (!diff_c[XLEN]) begin
            hi_d = diff_c[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b1};
         end else begin
            hi_d = shifted_c[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b0};
         end
      end
   end

   // Registered outputs follow the upcoming state
   always_comb begin
      busy_d   = (state_d == S_ITER) | (state_d == S_FIX);
      done_d   = (state_d == S_DONE);
      result_d = (state_q == S_FIX) ? fix_res_c : result_q;
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: results, latency, busy window, special
// cases, ignored start, mid-operation reset and back-to-back requests.
module tb_muldiv_unit;

   localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
   localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [2:0]  funct3;
   logic [31:0] op_a, op_b;
   logic        busy, done;
   logic [31:0] result;

   int total = 0;
   int bad   = 0;

   muldiv_unit #(.XLEN(32)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .funct3 (funct3),
      .op_a   (op_a),
      .op_b   (op_b),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Present a request, pass the accept edge, then scramble the operands
   task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      start  = 1'b1;
      funct3 = f;
      op_a   = a;
      op_b   = b;
      @(posedge clk); #1;
      start  = 1'b0;
      op_a   = 32'hDEAD_BEEF;
      op_b   = 32'h1234_5678;
   endtask

   // n0 = edges already elapsed since (and including) the accept edge
   task automatic wait_check(input string tag, input logic [31:0] exp_res, input int exp_lat, input int n0);
      int n;
      int bc;
      n  = n0;
      bc = n0 - 1;
      while (!done && n < 100) begin
         if (busy) bc++;
         @(posedge clk); #1;
         n++;
      end
      check({tag, " done"}, 32'(done), 32'd1);
      check({tag, " res"}, result, exp_res);
      check({tag, " lat"}, 32'(n), 32'(exp_lat));
      check({tag, " busycnt"}, 32'(bc), 32'(exp_lat - 1));
      check({tag, " busy0"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int dones;
      reset = 1'b1; start = 1'b0; funct3 = 3'b000; op_a = '0; op_b = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst result", result, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      start_op(F_MUL, 32'd7, 32'hFFFF_FFFD);          wait_check("mul", 32'hFFFF_FFEB, 34, 1);
      @(posedge clk); #1;
      check("done pulse", 32'(done), 32'd0);
      start_op(F_MULH, 32'h8000_0000, 32'h8000_0000); wait_check("mulh", 32'h4000_0000, 34, 1);
      @(posedge clk); #1;
      start_op(F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_check("mulhu", 32'hFFFF_FFFE, 34, 1);
      @(posedge clk); #1;
      start_op(F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_check("mulhsu", 32'hFFFF_FFFF, 34, 1);
      @(posedge clk); #1;
      start_op(F_DIV, 32'hFFFF_FFF9, 32'd2);          wait_check("div", 32'hFFFF_FFFD, 34, 1);
      @(posedge clk); #1;
      start_op(F_REM, 32'hFFFF_FFF9, 32'd2);          wait_check("rem", 32'hFFFF_FFFF, 34, 1);
      @(posedge clk); #1;
      start_op(F_DIVU, 32'd100, 32'd7);               wait_check("divu", 32'd14, 34, 1);
      @(posedge clk); #1;
      start_op(F_REMU, 32'd100, 32'd7);               wait_check("remu", 32'd2, 34, 1);
      @(posedge clk); #1;
      start_op(F_DIV, 32'd5, 32'd0);                  wait_check("div0", 32'hFFFF_FFFF, 2, 1);
      @(posedge clk); #1;
      start_op(F_REMU, 32'd5, 32'd0);                 wait_check("remu0", 32'd5, 2, 1);
      @(posedge clk); #1;
      start_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);  wait_check("divovf", 32'h8000_0000, 2, 1);
      @(posedge clk); #1;
      start_op(F_REM, 32'h8000_0000, 32'hFFFF_FFFF);  wait_check("removf", 32'd0, 2, 1);
      @(posedge clk); #1;

      // Start pulsed mid-multiply must not disturb it
      start_op(F_MUL, 32'd7, 32'hFFFF_FFFD);
      repeat (4) @(posedge clk);
      #1;
      start = 1'b1; funct3 = F_DIVU; op_a = 32'd50; op_b = 32'd5;
      @(posedge clk); #1;
      start = 1'b0;
      wait_check("mul ign", 32'hFFFF_FFEB, 34, 6);
      @(posedge clk); #1;

      // Reset in the middle of a divide aborts it
      start_op(F_DIV, 32'd100, 32'd7);
      repeat (9) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("abort busy", 32'(busy), 32'd0);
      check("abort done", 32'(done), 32'd0);
      check("abort result", result, 32'd0);
      dones = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) dones++;
      end
      check("abort nodone", 32'(dones), 32'd0);
      start_op(F_DIVU, 32'd9, 32'd3);                 wait_check("divu fresh", 32'd3, 34, 1);
      @(posedge clk); #1;

      // Back-to-back: second request issued during the DONE cycle
      start_op(F_MUL, 32'd3, 32'd4);                  wait_check("b2b mul", 32'd12, 34, 1);
      start_op(F_DIVU, 32'd12, 32'd5);
      check("b2b drop", 32'(done), 32'd0);
      check("b2b busy", 32'(busy), 32'd1);
      wait_check("b2b divu", 32'd2, 34, 1);
      @(posedge clk); #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
